// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR address constants
//   - CSR opcode encodings (register and immediate forms)
//   - mstatus bit positions and the interrupt bit base in mie/mip
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Bit 2 set selects the zero-extended immediate as the source operand.
    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    localparam int unsigned IRQ_BASE = 16;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with independently writable 32-bit halves.
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : count enable
//   wr_lo_i      : load wdata_i into bits [31:0] (upper half held)
//   wr_hi_i      : load wdata_i into bits [63:32] (lower half held)
//   wdata_i      : write data
//   value_o      : current count
// A write wins over the increment in the same cycle.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else if (wr_lo_i) begin
            value_q[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            value_q[63:32] <= wdata_i;
        end else if (inc_i) begin
            value_q <= value_q + 64'd1;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/csr_file_irq.sv
// csr_file_irq: single-cycle machine-mode CSR file with interrupt pending/cause logic.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   opcode_i, addr_i  : CSR operation and address
//   write_enable_i    : CSR instruction commit
//   rs1_data_i        : register source operand
//   imm_data_i        : zero-extended immediate source operand
//   pc_i, trap_i      : trap entry and PC of the trapping instruction
//   mcause_i, mtval_i : trap cause / value captured on trap entry
//   mret_i            : mret commit
//   instr_retired_i   : one instruction retired this cycle
//   irq_i             : level-sensitive external interrupt lines
//   read_data_o       : combinational read of addr_i
//   illegal_o         : access to addr_i is illegal
//   mie_o, mtvec_o, mepc_o, mstatus_mie_o : register views
//   irq_pending_o, irq_cause_o            : enabled interrupt pending and its mcause value
module csr_file_irq
    import csr_pkg::*;
#(
    parameter int unsigned IRQ_NUM     = 16,
    parameter bit          COUNTERS_EN = 1'b1,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2:0]         opcode_i,
    input  logic [11:0]        addr_i,
    input  logic               write_enable_i,
    input  logic [31:0]        rs1_data_i,
    input  logic [31:0]        imm_data_i,
    input  logic [31:0]        pc_i,
    input  logic               trap_i,
    input  logic [31:0]        mcause_i,
    input  logic [31:0]        mtval_i,
    input  logic               mret_i,
    input  logic               instr_retired_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic [31:0]        read_data_o,
    output logic               illegal_o,
    output logic [31:0]        mie_o,
    output logic [31:0]        mtvec_o,
    output logic [31:0]        mepc_o,
    output logic               mstatus_mie_o,
    output logic               irq_pending_o,
    output logic [31:0]        irq_cause_o
);

    localparam logic [31:0] MIE_MASK = ((32'd1 << IRQ_NUM) - 32'd1) << IRQ_BASE;

    logic               mstatus_mie_q;
    logic               mstatus_mpie_q;
    logic [31:0]        mie_q;
    logic [31:0]        mtvec_q;
    logic [31:0]        mscratch_q;
    logic [31:0]        mepc_q;
    logic [31:0]        mcause_q;
    logic [31:0]        mtval_q;
    logic [IRQ_NUM-1:0] irq_q;

    logic [31:0] mstatus_word;
    logic [31:0] mip_word;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        addr_ok;
    logic        read_only;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        op_valid;
    logic        csr_we;

    // MPP is hardwired to machine mode.
    always_comb begin
        mstatus_word = 32'h0000_1800;
        mstatus_word[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_word[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        mip_word = '0;
        mip_word[IRQ_BASE +: IRQ_NUM] = irq_q;
    end

    // Read mux and address decode.
    always_comb begin
        read_data_o = '0;
        addr_ok     = 1'b1;
        read_only   = 1'b0;
        unique case (addr_i)
            CSR_MSTATUS:  read_data_o = mstatus_word;
            CSR_MIE:      read_data_o = mie_q;
            CSR_MTVEC:    read_data_o = mtvec_q;
            CSR_MSCRATCH: read_data_o = mscratch_q;
            CSR_MEPC:     read_data_o = mepc_q;
            CSR_MCAUSE:   read_data_o = mcause_q;
            CSR_MTVAL:    read_data_o = mtval_q;
            CSR_MIP: begin
                read_data_o = mip_word;
                read_only   = 1'b1;
            end
            CSR_MHARTID: begin
                read_data_o = HART_ID;
                read_only   = 1'b1;
            end
            CSR_MCYCLE:    if (COUNTERS_EN) read_data_o = mcycle[31:0];    else addr_ok = 1'b0;
            CSR_MCYCLEH:   if (COUNTERS_EN) read_data_o = mcycle[63:32];   else addr_ok = 1'b0;
            CSR_MINSTRET:  if (COUNTERS_EN) read_data_o = minstret[31:0];  else addr_ok = 1'b0;
            CSR_MINSTRETH: if (COUNTERS_EN) read_data_o = minstret[63:32]; else addr_ok = 1'b0;
            default:       addr_ok = 1'b0;
        endcase
    end

    assign illegal_o = !addr_ok || (write_enable_i && read_only);

    // Write data: old value is the current read value of the addressed CSR.
    always_comb begin
        src      = opcode_i[2] ? imm_data_i : rs1_data_i;
        wdata    = '0;
        op_valid = 1'b1;
        case (csr_op_e'(opcode_i))
            CSR_RW, CSR_RWI: wdata = src;
            CSR_RS, CSR_RSI: wdata = src | read_data_o;
            CSR_RC, CSR_RCI: wdata = ~src & read_data_o;
            default:         op_valid = 1'b0;
        endcase
    end

    // A trap swallows any CSR write committed in the same cycle.
    assign csr_we = write_enable_i && op_valid && !illegal_o && !trap_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            irq_q          <= '0;
        end else begin
            irq_q <= irq_i;
            if (trap_i) begin
                mepc_q         <= pc_i & ~32'd3;
                mcause_q       <= mcause_i;
                mtval_q        <= mtval_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else begin
                if (mret_i) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end
                if (csr_we) begin
                    case (addr_i)
                        CSR_MSTATUS: begin
                            // mret owns mstatus in this cycle
                            if (!mret_i) begin
                                mstatus_mie_q  <= wdata[MSTATUS_MIE_BIT];
                                mstatus_mpie_q <= wdata[MSTATUS_MPIE_BIT];
                            end
                        end
                        CSR_MIE:      mie_q      <= wdata & MIE_MASK;
                        CSR_MTVEC:    mtvec_q    <= wdata;
                        CSR_MSCRATCH: mscratch_q <= wdata;
                        CSR_MEPC:     mepc_q     <= wdata & ~32'd3;
                        CSR_MCAUSE:   mcause_q   <= wdata;
                        CSR_MTVAL:    mtval_q    <= wdata;
                        default:      ;
                    endcase
                end
            end
        end
    end

    generate
        if (COUNTERS_EN) begin : g_counters
            csr_counter64 u_mcycle (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (1'b1),
                .wr_lo_i (csr_we && (addr_i == CSR_MCYCLE)),
                .wr_hi_i (csr_we && (addr_i == CSR_MCYCLEH)),
                .wdata_i (wdata),
                .value_o (mcycle)
            );
            csr_counter64 u_minstret (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (instr_retired_i && !trap_i),
                .wr_lo_i (csr_we && (addr_i == CSR_MINSTRET)),
                .wr_hi_i (csr_we && (addr_i == CSR_MINSTRETH)),
                .wdata_i (wdata),
                .value_o (minstret)
            );
        end else begin : g_no_counters
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

    // Lowest pending index wins; with nothing pending the cause points at line 0.
    logic [IRQ_NUM-1:0] pend;
    logic [4:0]         low_idx;

    always_comb begin
        pend    = irq_q & mie_q[IRQ_BASE +: IRQ_NUM];
        low_idx = '0;
        for (int k = IRQ_NUM - 1; k >= 0; k--) begin
            if (pend[k]) low_idx = 5'(k);
        end
        irq_cause_o = 32'h8000_0000 | (32'(IRQ_BASE) + 32'(low_idx));
    end

    assign irq_pending_o = mstatus_mie_q && |pend;
    assign mie_o         = mie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file_irq.sv
// Directed self-checking bench for csr_file_irq (default parameters) plus a
// second instance without counters for the illegal-address case.
module tb_csr_file_irq;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  opcode = 3'b000;
    logic [11:0] addr = 12'h300;
    logic        we = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic        trap = 1'b0;
    logic [31:0] mcause_in = '0;
    logic [31:0] mtval_in = '0;
    logic        mret = 1'b0;
    logic        retired = 1'b0;
    logic [15:0] irq = '0;

    logic [31:0] rdata, mie_v, mtvec_v, mepc_v, cause;
    logic        illegal, gmie, pending;

    logic [11:0] addr2 = 12'hB00;
    logic [31:0] rdata2, mie2, mtvec2, mepc2, cause2;
    logic        illegal2, gmie2, pending2;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    csr_file_irq u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .opcode_i        (opcode),
        .addr_i          (addr),
        .write_enable_i  (we),
        .rs1_data_i      (rs1),
        .imm_data_i      (imm),
        .pc_i            (pc),
        .trap_i          (trap),
        .mcause_i        (mcause_in),
        .mtval_i         (mtval_in),
        .mret_i          (mret),
        .instr_retired_i (retired),
        .irq_i           (irq),
        .read_data_o     (rdata),
        .illegal_o       (illegal),
        .mie_o           (mie_v),
        .mtvec_o         (mtvec_v),
        .mepc_o          (mepc_v),
        .mstatus_mie_o   (gmie),
        .irq_pending_o   (pending),
        .irq_cause_o     (cause)
    );

    csr_file_irq #(
        .IRQ_NUM     (4),
        .COUNTERS_EN (1'b0),
        .HART_ID     (32'd5)
    ) u_dut_nocnt (
        .clk_i           (clk),
        .rst_i           (rst),
        .opcode_i        (opcode),
        .addr_i          (addr2),
        .write_enable_i  (1'b0),
        .rs1_data_i      (rs1),
        .imm_data_i      (imm),
        .pc_i            (pc),
        .trap_i          (trap),
        .mcause_i        (mcause_in),
        .mtval_i         (mtval_in),
        .mret_i          (mret),
        .instr_retired_i (retired),
        .irq_i           (irq[3:0]),
        .read_data_o     (rdata2),
        .illegal_o       (illegal2),
        .mie_o           (mie2),
        .mtvec_o         (mtvec2),
        .mepc_o          (mepc2),
        .mstatus_mie_o   (gmie2),
        .irq_pending_o   (pending2),
        .irq_cause_o     (cause2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
            $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        we   = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic csr_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
        opcode = op;
        addr   = a;
        rs1    = d;
        imm    = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_cause", cause, 32'h8000_0010);
        chk("rst_mie_o", mie_v, 32'd0);
        rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
        chk("rst_illegal", 32'(illegal), 32'd0);

        // Reset clears a written CSR and the cycle counter
        csr_op(CSR_RW, CSR_MSCRATCH, 32'hDEAD_BEEF);
        rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "mscratch_wr");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(CSR_MSCRATCH, 32'd0, "mscratch_rst");
        rd(CSR_MCYCLE, 32'd0, "mcycle_rst");
        chk("pending_rst", 32'(pending), 32'd0);

        // CSR read-modify-write ops on mie
        csr_op(CSR_RW, CSR_MIE, 32'h0001_0000);
        csr_op(CSR_RS, CSR_MIE, 32'h0002_0000);
        rd(CSR_MIE, 32'h0003_0000, "mie_rs");
        csr_op(CSR_RCI, CSR_MIE, 32'd0);
        rd(CSR_MIE, 32'h0003_0000, "mie_rci0");
        csr_op(CSR_RC, CSR_MIE, 32'h0001_0000);
        rd(CSR_MIE, 32'h0002_0000, "mie_rc");
        csr_op(CSR_RW, CSR_MIE, 32'hFFFF_FFFF);
        rd(CSR_MIE, 32'hFFFF_0000, "mie_mask");
        csr_op(CSR_RW, CSR_MEPC, 32'h0000_2007);
        chk("mepc_align", mepc_v, 32'h0000_2004);
        csr_op(CSR_RWI, CSR_MTVEC, 32'h0000_001F);
        chk("mtvec_rwi", mtvec_v, 32'h0000_001F);
        csr_op(3'b100, CSR_MSCRATCH, 32'h1234_5678);
        rd(CSR_MSCRATCH, 32'd0, "reserved_op");

        // Trap with a same-cycle mepc write, then mret
        csr_op(CSR_RSI, CSR_MSTATUS, 32'h0000_0008);
        rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_mie1");
        opcode    = CSR_RW;
        addr      = CSR_MEPC;
        rs1       = 32'h0000_4444;
        we        = 1'b1;
        trap      = 1'b1;
        pc        = 32'h0000_1002;
        mcause_in = 32'h0000_0002;
        mtval_in  = 32'h0000_0055;
        tick();
        trap = 1'b0;
        we   = 1'b0;
        chk("trap_mepc", mepc_v, 32'h0000_1000);
        rd(CSR_MSTATUS, 32'h0000_1880, "trap_mstatus");
        rd(CSR_MCAUSE, 32'h0000_0002, "trap_mcause");
        rd(CSR_MTVAL, 32'h0000_0055, "trap_mtval");
        // mret with a simultaneous mstatus write: the write is dropped
        opcode = CSR_RW;
        addr   = CSR_MSTATUS;
        rs1    = 32'd0;
        we     = 1'b1;
        mret   = 1'b1;
        tick();
        mret = 1'b0;
        we   = 1'b0;
        rd(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");
        chk("mret_gmie", 32'(gmie), 32'd1);

        // Interrupt pending and priority
        csr_op(CSR_RW, CSR_MIE, 32'h0005_0000);
        chk("irq_idle", 32'(pending), 32'd0);
        irq = 16'h0005;
        #1;
        chk("irq_latency", 32'(pending), 32'd0);
        tick();
        chk("irq_pending", 32'(pending), 32'd1);
        chk("irq_cause0", cause, 32'h8000_0010);
        irq = 16'h0004;
        tick();
        chk("irq_cause2", cause, 32'h8000_0012);
        rd(CSR_MIP, 32'h0004_0000, "mip_read");
        irq = 16'h0008;
        tick();
        chk("irq_masked", 32'(pending), 32'd0);
        irq = 16'h0000;
        tick();

        // Counter wrap and split write
        csr_op(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFE);
        rd(CSR_MCYCLE, 32'hFFFF_FFFE, "mcycle_load");
        csr_op(CSR_RW, CSR_MCYCLEH, 32'd0);
        rd(CSR_MCYCLE, 32'hFFFF_FFFE, "mcycle_hold");
        tick();
        rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_ff");
        tick();
        rd(CSR_MCYCLE, 32'd0, "mcycle_wrap");
        rd(CSR_MCYCLEH, 32'd1, "mcycleh_carry");

        // minstret ignores retirements on trap cycles
        csr_op(CSR_RW, CSR_MINSTRET, 32'd10);
        retired = 1'b1;
        trap    = 1'b1;
        pc      = 32'h0000_3000;
        tick();
        trap = 1'b0;
        rd(CSR_MINSTRET, 32'd10, "minstret_trap");
        tick();
        retired = 1'b0;
        rd(CSR_MINSTRET, 32'd11, "minstret_inc");
        rd(CSR_MINSTRETH, 32'd0, "minstreth");

        // Illegal accesses
        opcode = CSR_RW;
        addr   = CSR_MIP;
        rs1    = 32'hFFFF_FFFF;
        we     = 1'b1;
        #1;
        chk("mip_wr_illegal", 32'(illegal), 32'd1);
        tick();
        we = 1'b0;
        rd(CSR_MIP, 32'd0, "mip_unchanged");
        chk("mip_rd_legal", 32'(illegal), 32'd0);
        addr = 12'h7C0;
        we   = 1'b1;
        #1;
        chk("bad_addr_illegal", 32'(illegal), 32'd1);
        chk("bad_addr_data", rdata, 32'd0);
        tick();
        we = 1'b0;
        rd(CSR_MHARTID, 32'd0, "mhartid");
        addr = CSR_MHARTID;
        we   = 1'b1;
        #1;
        chk("mhartid_wr_illegal", 32'(illegal), 32'd1);
        we = 1'b0;
        chk("mie_after_illegal", mie_v, 32'h0005_0000);

        // Instance without counters
        addr2 = CSR_MCYCLE;
        #1;
        chk("nocnt_b00_illegal", 32'(illegal2), 32'd1);
        addr2 = CSR_MHARTID;
        #1;
        chk("nocnt_hartid", rdata2, 32'd5);
        chk("nocnt_hartid_legal", 32'(illegal2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
